// File: rtl/cpu_bcd_seq.sv
// CHIP-8 FX33 sequencer: writes the BCD digits of a latched byte to I, I+1, I+2 over a req/ack port.
// Optional macro CPU_BCD_SEQ_BOUNDS_EN adds addr_err and skips writes when I+2 would leave the address space.

module cpu_bcd (
  input  logic [7:0] value,
  output logic [1:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  // Constant divisors only, so this reduces to small combinational logic.
  assign hundreds = 2'(value / 8'd100);
  assign tens     = 4'((value % 8'd100) / 8'd10);
  assign ones     = 4'(value % 8'd10);
endmodule

module cpu_bcd_seq #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        value,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack
`ifdef CPU_BCD_SEQ_BOUNDS_EN
  ,
  output logic              addr_err
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR_H = 3'd1,
    WR_T = 3'd2,
    WR_O = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t            state_q, state_nx;
  logic [7:0]        value_q;
  logic [ADDR_W-1:0] base_q;
  logic [1:0]        bcd_h;
  logic [3:0]        bcd_t;
  logic [3:0]        bcd_o;
  logic              accept;
  logic              oob;

  assign accept = (state_q == IDLE) && start;

`ifdef CPU_BCD_SEQ_BOUNDS_EN
  localparam logic [ADDR_W-1:0] LAST_OK = {ADDR_W{1'b1}} - ADDR_W'(2);
  logic err_q;

  assign oob = (base_addr > LAST_OK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= oob;
  end

  assign addr_err = (state_q == FIN) && err_q;
`else
  assign oob = 1'b0;
`endif

  cpu_bcd u_bcd (
    .value    (value_q),
    .hundreds (bcd_h),
    .tens     (bcd_t),
    .ones     (bcd_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      value_q <= 8'd0;
      base_q  <= '0;
    end else begin
      state_q <= state_nx;
      if (accept) begin
        value_q <= value;
        base_q  <= base_addr;
      end
    end
  end

  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      IDLE: if (start) state_nx = oob ? FIN : WR_H;
      WR_H: if (mem_ack) state_nx = WR_T;
      WR_T: if (mem_ack) state_nx = WR_O;
      WR_O: if (mem_ack) state_nx = FIN;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decode only the state register, so reset clears them without a clock edge.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'd0;
    unique case (state_q)
      WR_H: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = base_q;
        mem_wdata = {6'd0, bcd_h};
      end
      WR_T: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = base_q + ADDR_W'(1);
        mem_wdata = {4'd0, bcd_t};
      end
      WR_O: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = base_q + ADDR_W'(2);
        mem_wdata = {4'd0, bcd_o};
      end
      FIN:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_bcd_seq.sv
// Bench for cpu_bcd_seq: directed cases plus randomized values, bases and ack delays against a digit model.
module tb_cpu_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  value;
  logic [11:0] base_addr;
  logic        busy, done, mem_req, mem_ack;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
`ifdef CPU_BCD_SEQ_BOUNDS_EN
  logic        addr_err;
`endif

  int checks = 0;
  int failures = 0;

  cpu_bcd_seq #(.ADDR_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .value     (value),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack)
`ifdef CPU_BCD_SEQ_BOUNDS_EN
    ,
    .addr_err  (addr_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req"}, 32'(mem_req), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // One FX33 store; dly<0 draws a random 0..3 wait per write. inject pulses a second start (value 7) during the tens write.
  task automatic do_seq(input logic [7:0] v, input logic [11:0] b, input int dly, input bit inject);
    logic [7:0]  dig [3];
    logic [11:0] ea;
    int idx, waited, cur_d, cyc, exp_lat;
    bit done_seen, injected;
    dig[0] = 8'(v / 100);
    dig[1] = 8'((v / 10) % 10);
    dig[2] = 8'(v % 10);
    @(negedge clk);
    start = 1'b1; value = v; base_addr = b; mem_ack = 1'b0;
    idx = 0; waited = 0; cyc = 0; done_seen = 1'b0; injected = 1'b0;
    cur_d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
    exp_lat = 1 + cur_d + 1;
    while (!done_seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      value = 8'($urandom);
      base_addr = 12'($urandom);
      if (idx == 3) begin
        mem_ack = 1'b0;
        done_seen = 1'b1;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_fin", 32'(busy), 32'd0);
        check("req_fin", 32'(mem_req), 32'd0);
        check("latency", cyc, exp_lat);
`ifdef CPU_BCD_SEQ_BOUNDS_EN
        check("addr_err_ok", 32'(addr_err), 32'd0);
`endif
      end else begin
        ea = b + 12'(idx);
        check("busy", 32'(busy), 32'd1);
        check("done_early", 32'(done), 32'd0);
        check("req", 32'(mem_req), 32'd1);
        check("addr", 32'(mem_addr), 32'(ea));
        check("wdata", 32'(mem_wdata), 32'(dig[idx]));
        if (inject && idx == 1 && !injected) begin
          start = 1'b1; value = 8'd7; injected = 1'b1;
        end
        if (waited >= cur_d) begin
          mem_ack = 1'b1; idx++; waited = 0;
          if (idx < 3) begin
            cur_d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
            exp_lat += cur_d + 1;
          end
        end else begin
          mem_ack = 1'b0; waited++;
        end
      end
    end
    check("seq_completed", 32'(done_seen), 32'd1);
    mem_ack = 1'b0; start = 1'b0;
    @(negedge clk);
    check_idle("post_done");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; value = 8'd0; base_addr = 12'd0; mem_ack = 1'b0;
    #12;
    check_idle("reset");
    check("reset_addr", 32'(mem_addr), 32'd0);
    check("reset_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ack tied high, slow ack, wrap at top of memory, and edge of legal range
    do_seq(8'd100, 12'h300, 0, 1'b0);
    do_seq(8'd255, 12'h200, 2, 1'b0);
`ifndef CPU_BCD_SEQ_BOUNDS_EN
    do_seq(8'd99, 12'hFFF, 0, 1'b0);
`endif
    do_seq(8'd123, 12'hFFD, 1, 1'b0);
    do_seq(8'd0, 12'h000, 0, 1'b0);

    // second start during the tens write is dropped; nothing follows
    do_seq(8'd123, 12'h080, 1, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check_idle("lost_start");
    end

    // async reset mid-write with ack low
    @(negedge clk);
    start = 1'b1; value = 8'd200; base_addr = 12'h050;
    @(negedge clk);
    start = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("pre_rst_req", 32'(mem_req), 32'd1);
    check("pre_rst_addr", 32'(mem_addr), 32'h051);
    #2 rst = 1'b1;
    #1;
    check_idle("async_rst");
    check("async_rst_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_rst");
    do_seq(8'd42, 12'h100, 0, 1'b0);

    // ack while idle is ignored
    @(negedge clk);
    mem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("idle_ack");
    end
    mem_ack = 1'b0;

`ifdef CPU_BCD_SEQ_BOUNDS_EN
    @(negedge clk);
    start = 1'b1; value = 8'd99; base_addr = 12'hFFF;
    @(negedge clk);
    start = 1'b0;
    check("oob_done", 32'(done), 32'd1);
    check("oob_err", 32'(addr_err), 32'd1);
    check("oob_req", 32'(mem_req), 32'd0);
    check("oob_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_idle("oob_after");
    check("oob_err_clear", 32'(addr_err), 32'd0);
`endif

    for (int n = 0; n < 25; n++) begin
      logic [11:0] rb;
      rb = 12'($urandom);
`ifdef CPU_BCD_SEQ_BOUNDS_EN
      if (rb > 12'hFFD) rb = 12'hFFD;
`endif
      do_seq(8'($urandom), rb, -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_bcd_seq.md
Name: cpu_bcd_seq

Overview:
- Sequencer for the CHIP-8 FX33 instruction (store BCD of VX at I, I+1, I+2).
- Latches an 8-bit register value and a base address on a start pulse, then converts the value through an internal cpu_bcd instance.
- Issues three byte writes to RAM over a req/ack handshake: hundreds, then tens, then ones.
- Sits between the CPU execute stage and the memory arbiter; the CPU stalls while busy is high.

Parameters:
- ADDR_W, 12, memory address width in bits; the CHIP-8 space is 4 KiB.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a BCD store; sampled only in IDLE.
- value  input  8  binary source value (VX); sampled when start is accepted.
- base_addr  input  ADDR_W  destination address I; sampled when start is accepted.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the third write completes.
- mem_req  output  1  write request to the memory arbiter.
- mem_addr  output  ADDR_W  write address; valid while mem_req is high.
- mem_wdata  output  8  write data: {4'b0, digit}; valid while mem_req is high.
- mem_ack  input  1  arbiter accepts the write on the rising edge where mem_req && mem_ack.

Behaviour:
- Reset (async, any time, including mid-sequence):
  - state=IDLE; busy=0, done=0, mem_req=0, mem_addr=0, mem_wdata=0.
  - Latched value and address are cleared to 0.
  - An in-flight write is abandoned; no further writes are issued.
- Conversion:
  - The internal cpu_bcd is driven from the latched value.
  - Its outputs are combinational: hundreds 0-2, tens 0-9, ones 0-9.
- States:
  - IDLE: start=1 → latch value and base_addr, go to WR_H. Otherwise stay.
  - WR_H: mem_req=1, mem_addr=base, mem_wdata=hundreds. On ack go to WR_T.
  - WR_T: mem_req=1, mem_addr=base+1, mem_wdata=tens. On ack go to WR_O.
  - WR_O: mem_req=1, mem_addr=base+2, mem_wdata=ones. On ack go to FIN.
  - FIN: done=1, busy=0, mem_req=0. Unconditionally go to IDLE next cycle.
- Outputs by state:
  - busy=1 in WR_H, WR_T and WR_O only.
  - mem_req is registered, from state; it never drops without an ack.
- Handshake rules:
  - mem_addr and mem_wdata are stable while mem_req=1 and no ack has occurred.
  - mem_ack may be high on the first cycle of a request, giving one write per cycle.
  - mem_ack while mem_req=0 is ignored.
- Latency:
  - Minimum: start accepted at edge N, writes complete at N+1, N+2, N+3, done high during cycle N+4.
  - Each wait-state cycle without ack adds one cycle.
- Start while busy or in FIN: ignored; no queueing.
- start in the same cycle a reset deasserts: ignored until the first clock edge after reset release.
- Address arithmetic: modulo 2^ADDR_W by default (base=0xFFF → writes to 0xFFF, 0x000, 0x001); see Optional Feature.
- Changes to value or base_addr after start is accepted have no effect on the sequence.

Optional Feature:
- Macro: CPU_BCD_SEQ_BOUNDS_EN.
- Defined:
  - Adds output port addr_err (1 bit, reset 0).
  - At start, if base_addr > 2^ADDR_W-3, no write is issued and the sequence goes straight to FIN.
  - In that case done pulses with addr_err=1 in the same cycle. addr_err is 0 on normal completion.
- Not defined: no addr_err port; addresses wrap modulo 2^ADDR_W as above.

Test Plan:
- value=100, base=0x300, ack tied high:
  - writes (0x300,0x01), (0x301,0x00), (0x302,0x00) on three consecutive edges.
  - done one cycle later; busy high for exactly 3 cycles.
- value=255, base=0x200, ack delayed 2 cycles per write:
  - data 0x02, 0x05, 0x05.
  - addr/wdata stable during waits; done at start+10 cycles.
- value=99, base=0xFFF, no bounds macro:
  - writes (0xFFF,0x00), (0x000,0x09), (0x001,0x09).
  - With CPU_BCD_SEQ_BOUNDS_EN: no mem_req; done=1 and addr_err=1 on the cycle after start.
- Second start with value=7 pulsed while in WR_T of value=123:
  - only 0x01, 0x02, 0x03 are written; a single done pulse; the second start is lost.
- rst asserted asynchronously mid-cycle during WR_T with ack low:
  - mem_req, busy and done drop immediately, with no clock edge needed.
  - After release the block is in IDLE; a new start (value=42, base=0x100) writes 0x00, 0x04, 0x02 correctly.
- mem_ack pulsed while idle, and value/base changed after start:
  - no spurious writes or state change from the idle ack.
  - The written data and addresses match the values latched at start.
